sd_img_arbiter: RTL and testbench
=================================

# sd_img_arbiter

Parametrised arbiter sharing the single user_io SD-image port among CHANNELS image clients (FDC drives, virtual SD card, future HDD). It replaces the fixed busy-flag muxing of LBA and buffer data with round-robin grant, request latching, an ack timeout and per-channel drive-ready tracking. It sits between user_io (sd_* / img_* side) and the client controllers (u765, sd_card, ...).

## Interface
- CHANNELS, 3, number of image clients (1..8)
- LBA_W, 32, LBA width
- TIMEOUT, 24'd2_800_000, clock cycles allowed between grant and first sd_ack (0 disables)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- cli_rd  in  CHANNELS  per-client read request, level, held until cli_ack seen
- cli_wr  in  CHANNELS  per-client write request, same rules
- cli_lba  in  CHANNELS*LBA_W  client LBAs, channel i at [i*LBA_W +: LBA_W]
- cli_din  in  CHANNELS*8  client buffer bytes toward host, channel i at [i*8 +: 8]
- cli_ack  out  CHANNELS  sd_ack routed to granted client only
- cli_err  out  CHANNELS  one-cycle pulse on timeout abort
- sd_rd  out  CHANNELS  to user_io, at most one bit set
- sd_wr  out  CHANNELS  to user_io, at most one bit set
- sd_ack  in  1  from user_io
- sd_lba  out  LBA_W  latched LBA of granted request
- sd_din  out  8  cli_din of granted channel (combinational mux)
- img_mounted  in  CHANNELS  mount pulses from user_io
- img_size  in  64  image size, valid with img_mounted
- ready  out  CHANNELS  per-drive image present

## Operation
- States: IDLE, REQ, XFER.
- IDLE: pend = cli_rd | cli_wr. If pend != 0, select first set bit scanning from (last+1) mod CHANNELS upward with wrap; latch grant index g, op (rd wins if both set for g; wr stays pending), sd_lba <= cli_lba[g]; go REQ. After reset last = CHANNELS-1, so channel 0 scanned first.
- REQ: sd_rd[g] or sd_wr[g] = 1 per latched op. On sd_ack=1 -> XFER, clear sd_rd/sd_wr. If TIMEOUT != 0 and counter reaches TIMEOUT without ack: clear request, pulse cli_err[g], last <= g, -> IDLE.
- XFER: wait sd_ack=0; then last <= g, -> IDLE.
- cli_ack[i] = sd_ack & (state != IDLE) & (g == i). sd_din = cli_din[g] in all states.
- Client request dropping in REQ before ack is ignored (request already issued to host; transfer completes normally).
- ready: for every i with img_mounted[i]=1 in a cycle, ready[i] <= (img_size != 0). Simultaneous pulses on several channels all update in that cycle. Independent of arbiter state.

## Timing
- Reset: state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, cli_err=0, ready=0, counter 0, g=0, last=CHANNELS-1. Asserting reset mid-transfer aborts immediately; no cli_err.
- Request seen in IDLE at edge N -> sd_rd/sd_wr high from edge N+1 (1-cycle latency), sd_lba valid same cycle.
- sd_ack rise at edge M -> sd_rd/sd_wr low after edge M+1; cli_ack combinational with sd_ack.
- sd_ack fall at edge K -> IDLE at K+1; next grant earliest K+2.
- Timeout counter LBA-independent, counts REQ cycles from 0; abort on the cycle count equals TIMEOUT, cli_err high exactly one cycle.
- Round-robin: with all channels continuously requesting, grants rotate 0,1,2,0,...

## Test plan
- Single read ch1 (lba 0x123): cli_rd=3'b010 -> next cycle sd_rd=3'b010, sd_lba=0x123; ack 1 for 10 cycles -> cli_ack=3'b010 only during ack; sd_rd low after ack rise; IDLE after ack fall.
- Contention: cli_rd=3'b111 held, host acks each -> grant order 0,1,2,0; never two sd_rd bits set.
- Rd+wr on ch0 together: first transfer sd_rd=3'b001, second sd_wr=3'b001.
- Timeout TIMEOUT=16, no ack: sd_rd high 16 cycles, then low, cli_err[g] one-cycle pulse, next pending channel granted.
- Mount: img_mounted=3'b011, img_size=737280 -> ready=3'b011; then img_mounted=3'b001, img_size=0 -> ready=3'b010.
- Reset low during XFER: sd_rd/sd_wr/cli_err/ready all 0 immediately; after release first grant goes to channel 0.

Source files
------------

// File: rtl/sd_img_arbiter_if.sv
// Bundle of the client-side, host-side and mount signals around the SD-image arbiter.
// The master modport is the arbiter itself; the slave modport is its environment.
interface sd_img_arbiter_if #(
    parameter int CHANNELS = 3,
    parameter int LBA_W    = 32
);
    logic [CHANNELS-1:0]       cli_rd;
    logic [CHANNELS-1:0]       cli_wr;
    logic [CHANNELS*LBA_W-1:0] cli_lba;
    logic [CHANNELS*8-1:0]     cli_din;
    logic [CHANNELS-1:0]       cli_ack;
    logic [CHANNELS-1:0]       cli_err;
    logic [CHANNELS-1:0]       sd_rd;
    logic [CHANNELS-1:0]       sd_wr;
    logic                      sd_ack;
    logic [LBA_W-1:0]          sd_lba;
    logic [7:0]                sd_din;
    logic [CHANNELS-1:0]       img_mounted;
    logic [63:0]               img_size;
    logic [CHANNELS-1:0]       ready;

    modport master (
        input  cli_rd, cli_wr, cli_lba, cli_din, sd_ack, img_mounted, img_size,
        output cli_ack, cli_err, sd_rd, sd_wr, sd_lba, sd_din, ready
    );

    modport slave (
        output cli_rd, cli_wr, cli_lba, cli_din, sd_ack, img_mounted, img_size,
        input  cli_ack, cli_err, sd_rd, sd_wr, sd_lba, sd_din, ready
    );
endinterface

// File: rtl/sd_img_arbiter.sv
// Round-robin arbiter sharing the single user_io SD-image port among several image
// clients, with request latching, ack timeout and per-drive image-present tracking.
module sd_img_arbiter #(
    parameter int          CHANNELS = 3,
    parameter int          LBA_W    = 32,
    parameter logic [23:0] TIMEOUT  = 24'd2_800_000
) (
    input  logic             clock,
    input  logic             reset,
    sd_img_arbiter_if.master bus
);
    localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t              state_r, stateNext_s;
    logic [IDXW-1:0]     grant_r, grantNext_s;
    logic [IDXW-1:0]     last_r, lastNext_s;
    logic [CHANNELS-1:0] sdRd_r, sdRdNext_s;
    logic [CHANNELS-1:0] sdWr_r, sdWrNext_s;
    logic [LBA_W-1:0]    sdLba_r, sdLbaNext_s;
    logic [CHANNELS-1:0] cliErr_r, cliErrNext_s;
    logic [23:0]         count_r, countNext_s;
    logic [CHANNELS-1:0] ready_r;
    logic [CHANNELS-1:0] cliAck_s;
    logic [CHANNELS-1:0] pend_s;
    logic [IDXW:0]       pick_s;

    // First pending channel scanning upward from last+1 with wrap; MSB flags a hit.
    function automatic logic [IDXW:0] rrPick(input logic [CHANNELS-1:0] pend,
                                             input logic [IDXW-1:0] last);
        logic            found;
        logic [IDXW-1:0] pick;
        int              idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(last) + k) % CHANNELS;
            if (!found && pend[IDXW'(idx)]) begin
                found = 1'b1;
                pick  = IDXW'(idx);
            end
        end
        return {found, pick};
    endfunction

    assign pend_s = bus.cli_rd | bus.cli_wr;
    assign pick_s = rrPick(pend_s, last_r);

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        stateNext_s  = state_r;
        grantNext_s  = grant_r;
        lastNext_s   = last_r;
        sdRdNext_s   = sdRd_r;
        sdWrNext_s   = sdWr_r;
        sdLbaNext_s  = sdLba_r;
        cliErrNext_s = '0;
        countNext_s  = count_r;
        case (state_r)
            IDLE: begin
                countNext_s = 24'd0;
                if (pick_s[IDXW]) begin
                    grantNext_s = pick_s[IDXW-1:0];
                    sdLbaNext_s = bus.cli_lba[int'(pick_s[IDXW-1:0]) * LBA_W +: LBA_W];
                    sdRdNext_s  = '0;
                    sdWrNext_s  = '0;
                    // Read wins when both are requested; the write stays pending.
                    if (bus.cli_rd[pick_s[IDXW-1:0]]) begin
                        sdRdNext_s[pick_s[IDXW-1:0]] = 1'b1;
                    end else begin
                        sdWrNext_s[pick_s[IDXW-1:0]] = 1'b1;
                    end
                    stateNext_s = REQ;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            REQ: begin
                if (bus.sd_ack) begin
                    sdRdNext_s  = '0;
                    sdWrNext_s  = '0;
                    countNext_s = 24'd0;
                    stateNext_s = XFER;
                end else if ((TIMEOUT != 24'd0) && ((count_r + 24'd1) == TIMEOUT)) begin
                    sdRdNext_s            = '0;
                    sdWrNext_s            = '0;
                    countNext_s           = 24'd0;
                    cliErrNext_s[grant_r] = 1'b1;
                    lastNext_s            = grant_r;
                    stateNext_s           = IDLE;
                end else begin
                    countNext_s = count_r + 24'd1;
                end
            end
            XFER: begin
                if (!bus.sd_ack) begin
                    lastNext_s  = grant_r;
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = XFER;
                end
            end
            default: begin
                sdRdNext_s  = '0;
                sdWrNext_s  = '0;
                countNext_s = 24'd0;
                stateNext_s = IDLE;
            end
        endcase
    end

    // Grant FSM state and registered host-side outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            last_r   <= IDXW'(CHANNELS - 1);
            sdRd_r   <= '0;
            sdWr_r   <= '0;
            sdLba_r  <= '0;
            cliErr_r <= '0;
            count_r  <= 24'd0;
        end else begin
            state_r  <= stateNext_s;
            grant_r  <= grantNext_s;
            last_r   <= lastNext_s;
            sdRd_r   <= sdRdNext_s;
            sdWr_r   <= sdWrNext_s;
            sdLba_r  <= sdLbaNext_s;
            cliErr_r <= cliErrNext_s;
            count_r  <= countNext_s;
        end
    end

    // Image-present flags, updated by every mount pulse regardless of arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_r <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.img_mounted[i]) begin
                    ready_r[i] <= (bus.img_size != 64'd0);
                end else begin
                    ready_r[i] <= ready_r[i];
                end
            end
        end
    end

    // Host ack routed to the granted client only while a request is in flight.
    always_comb begin
        cliAck_s = '0;
        if (bus.sd_ack && (state_r != IDLE)) begin
            cliAck_s[grant_r] = 1'b1;
        end else begin
            cliAck_s = '0;
        end
    end

    assign bus.cli_ack = cliAck_s;
    assign bus.cli_err = cliErr_r;
    assign bus.sd_rd   = sdRd_r;
    assign bus.sd_wr   = sdWr_r;
    assign bus.sd_lba  = sdLba_r;
    assign bus.sd_din  = bus.cli_din[int'(grant_r) * 8 +: 8];
    assign bus.ready   = ready_r;
endmodule

// File: tb/tb_sd_img_arbiter.sv
// Directed self-checking bench for sd_img_arbiter with a short ack timeout.
module tb_sd_img_arbiter;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    sd_img_arbiter_if #(.CHANNELS(3), .LBA_W(32)) bus ();

    sd_img_arbiter #(.CHANNELS(3), .LBA_W(32), .TIMEOUT(24'd16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    // Waits (bounded) for any host request bit; a missing grant counts as a failure.
    task automatic waitGrant(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((bus.sd_rd | bus.sd_wr) != 3'b000) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checkValue(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        int hi;
        logic [1:0] order [4];
        total = 0;
        bad   = 0;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
        bus.cli_rd      = 3'b000;
        bus.cli_wr      = 3'b000;
        bus.cli_lba     = {32'h0000_0C00, 32'h0000_0123, 32'h0000_0A00};
        bus.cli_din     = {8'hC2, 8'hB1, 8'hA0};
        bus.sd_ack      = 1'b0;
        bus.img_mounted = 3'b000;
        bus.img_size    = 64'd0;
        reset           = 1'b0;
        #12;
        checkValue("rst_sd_rd", 64'(bus.sd_rd), 64'd0);
        checkValue("rst_sd_lba", 64'(bus.sd_lba), 64'd0);
        checkValue("rst_ready", 64'(bus.ready), 64'd0);
        checkValue("rst_cli_err", 64'(bus.cli_err), 64'd0);
        reset = 1'b1;
        step();

        // Single read on channel 1
        bus.cli_rd = 3'b010;
        step();
        checkValue("rd1_sd_rd", 64'(bus.sd_rd), 64'b010);
        checkValue("rd1_sd_wr", 64'(bus.sd_wr), 64'b000);
        checkValue("rd1_sd_lba", 64'(bus.sd_lba), 64'h123);
        checkValue("rd1_sd_din", 64'(bus.sd_din), 64'hB1);
        checkValue("rd1_ack_pre", 64'(bus.cli_ack), 64'b000);
        step(); step();
        checkValue("rd1_hold", 64'(bus.sd_rd), 64'b010);
        bus.sd_ack = 1'b1;
        #1;
        checkValue("rd1_cli_ack", 64'(bus.cli_ack), 64'b010);
        step();
        checkValue("rd1_rd_low", 64'(bus.sd_rd), 64'b000);
        bus.cli_rd = 3'b000;
        for (int i = 0; i < 9; i++) step();
        checkValue("rd1_ack_xfer", 64'(bus.cli_ack), 64'b010);
        bus.sd_ack = 1'b0;
        #1;
        checkValue("rd1_ack_drop", 64'(bus.cli_ack), 64'b000);
        step(); step();
        checkValue("rd1_idle", 64'(bus.sd_rd | bus.sd_wr), 64'd0);

        // Contention: all channels reading continuously
        doReset();
        bus.cli_rd = 3'b111;
        for (int n = 0; n < 4; n++) begin
            waitGrant("rr_grant");
            checkValue("rr_onehot", 64'($onehot(bus.sd_rd)), 64'd1);
            checkValue("rr_order", 64'(bus.sd_rd), 64'(3'b001 << order[n]));
            bus.sd_ack = 1'b1;
            step();
            step();
            bus.sd_ack = 1'b0;
            step();
        end
        bus.cli_rd = 3'b000;

        // Read and write together on channel 0
        doReset();
        bus.cli_rd = 3'b001;
        bus.cli_wr = 3'b001;
        waitGrant("rw_grant1");
        checkValue("rw_first_rd", 64'(bus.sd_rd), 64'b001);
        checkValue("rw_first_wr", 64'(bus.sd_wr), 64'b000);
        bus.sd_ack = 1'b1;
        step();
        bus.cli_rd = 3'b000;
        bus.sd_ack = 1'b0;
        step();
        waitGrant("rw_grant2");
        checkValue("rw_second_wr", 64'(bus.sd_wr), 64'b001);
        checkValue("rw_second_rd", 64'(bus.sd_rd), 64'b000);
        bus.sd_ack = 1'b1;
        step();
        bus.cli_wr = 3'b000;
        bus.sd_ack = 1'b0;
        step();

        // Timeout with no ack; channel 1 also pending
        doReset();
        bus.cli_rd = 3'b011;
        step();
        checkValue("to_first", 64'(bus.sd_rd), 64'b001);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.sd_rd == 3'b000) break;
            hi++;
        end
        checkValue("to_high_cycles", 64'(hi), 64'd16);
        checkValue("to_err_pulse", 64'(bus.cli_err), 64'b001);
        step();
        checkValue("to_err_clear", 64'(bus.cli_err), 64'b000);
        checkValue("to_next_grant", 64'(bus.sd_rd), 64'b010);
        bus.cli_rd = 3'b000;

        // Mount tracking
        doReset();
        bus.img_mounted = 3'b011;
        bus.img_size    = 64'd737280;
        step();
        bus.img_mounted = 3'b000;
        checkValue("mnt_ready1", 64'(bus.ready), 64'b011);
        bus.img_mounted = 3'b001;
        bus.img_size    = 64'd0;
        step();
        bus.img_mounted = 3'b000;
        checkValue("mnt_ready2", 64'(bus.ready), 64'b010);

        // Reset asserted during a transfer on channel 2
        bus.cli_rd = 3'b100;
        waitGrant("rx_grant");
        checkValue("rx_ch2", 64'(bus.sd_rd), 64'b100);
        bus.sd_ack = 1'b1;
        step();
        checkValue("rx_xfer_ack", 64'(bus.cli_ack), 64'b100);
        reset = 1'b0;
        #1;
        checkValue("rx_rst_rdwr", 64'(bus.sd_rd | bus.sd_wr), 64'd0);
        checkValue("rx_rst_err", 64'(bus.cli_err), 64'd0);
        checkValue("rx_rst_ready", 64'(bus.ready), 64'd0);
        checkValue("rx_rst_ack", 64'(bus.cli_ack), 64'd0);
        bus.sd_ack = 1'b0;
        bus.cli_rd = 3'b101;
        step();
        reset = 1'b1;
        step();
        checkValue("rx_after_grant", 64'(bus.sd_rd), 64'b001);
        bus.cli_rd = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
